// File: rtl/mem_bus_ctrl.sv
// Memory-access sequencer: turns controller read/write intent into a req/ack bus transaction.
// Latency: bus_req one cycle after the request; done and rdata one cycle after bus_ack.
// Backpressure: stall holds the controller until RESP; no new request is taken during REQ/RESP.
// Optional feature: MEMIF_TIMEOUT_EN aborts a hung REQ after TIMEOUT cycles and sets sticky bus_err.
module mem_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   tmo;

`ifdef MEMIF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // An ack in the limit cycle wins over the abort.
    assign tmo = (state == REQ) && !bus_ack && (cnt == CNT_MAX);

    // Count unacknowledged REQ cycles; cleared whenever REQ is left or not active, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state != REQ || bus_ack || tmo) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (tmo) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; RESP always returns to IDLE so a held request is not re-accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_rd || mem_wr) state_nxt = REQ;
            REQ:     if (bus_ack || tmo)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and completion outputs decoded from the state register, so reset drops bus_req at once.
    always_comb begin
        bus_req = (state == REQ);
        done    = (state == RESP);
        stall   = (mem_rd || mem_wr) && (state != RESP);
    end

    // Capture the access in IDLE, keep it stable through REQ, and register read data on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && (mem_rd || mem_wr)) begin
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_we    <= mem_wr;
            end
            if (state == REQ && !bus_we) begin
                if (bus_ack) begin
                    rdata <= bus_rdata;
                end else if (tmo) begin
                    rdata <= '0;
                end
            end
        end
    end

endmodule
